// File: rtl/mod3_frame_tx.sv
// Serial frame transmitter: shifts a parallel word out MSB-first and appends two
// check bits so the whole frame, read as a binary number, is divisible by 3.
module mod3_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic [1:0]        rem_r
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, CHK1, CHK0} state_t;

  state_t             state_r, state_s;
  logic [DATA_W-1:0]  shift_r, shift_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               bit_s, valid_s, sof_s, eof_s, accept_s;
  logic [1:0]         rem_s, rem_full_s, chk_next_s, chk_cur_s;

  // Remainder after appending bit b: (2*rem + b) mod 3, never producing 3.
  function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic b);
    logic [1:0] r;
    case (rem)
      2'd0:    r = {1'b0, b};
      2'd1:    r = b ? 2'd0 : 2'd2;
      2'd2:    r = b ? 2'd2 : 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Check bits c = (3 - R) mod 3 that make 4*V + c a multiple of 3.
  function automatic logic [1:0] chk_bits(input logic [1:0] rem);
    logic [1:0] c;
    case (rem)
      2'd0:    c = 2'b00;
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  assign in_ready = (state_r == IDLE) || (state_r == CHK0);

  // Next-state and next-output logic; rem_r trails out_bit by one cycle.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    cnt_s      = cnt_r;
    bit_s      = 1'b0;
    valid_s    = 1'b0;
    sof_s      = 1'b0;
    eof_s      = 1'b0;
    rem_s      = rem_r;
    accept_s   = in_valid && in_ready;
    rem_full_s = mod3_step(rem_r, out_bit);
    chk_next_s = chk_bits(rem_full_s);
    chk_cur_s  = chk_bits(rem_r);
    case (state_r)
      DATA: begin
        rem_s   = rem_full_s;
        valid_s = 1'b1;
        if (cnt_r != {CNT_W{1'b0}}) begin
          bit_s   = shift_r[DATA_W-1];
          shift_s = {shift_r[DATA_W-2:0], 1'b0};
          cnt_s   = cnt_r - 1'b1;
        end else begin
          state_s = CHK1;
          bit_s   = chk_next_s[1];
        end
      end
      CHK1: begin
        state_s = CHK0;
        valid_s = 1'b1;
        bit_s   = chk_cur_s[0];
        eof_s   = 1'b1;
      end
      IDLE, CHK0: begin
        if (accept_s) begin
          state_s = DATA;
          shift_s = {in_data[DATA_W-2:0], 1'b0};
          cnt_s   = CNT_W'(DATA_W - 1);
          bit_s   = in_data[DATA_W-1];
          valid_s = 1'b1;
          sof_s   = 1'b1;
          rem_s   = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      rem_r     <= 2'd0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      cnt_r     <= cnt_s;
      out_bit   <= bit_s;
      out_valid <= valid_s;
      out_sof   <= sof_s;
      out_eof   <= eof_s;
      rem_r     <= rem_s;
    end
  end

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Self-checking bench for mod3_frame_tx: directed frames plus randomized traffic
// against an arithmetic frame model and a serial mod-3 receiver model.
module tb_mod3_frame_tx;

  localparam int DATA_W = 8;
  localparam int FL     = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_bit, out_valid, out_sof, out_eof;
  logic [1:0]        rem_r;

  int n_checks = 0;
  int n_pass   = 0;
  int rx       = 0;

  typedef struct {
    bit b;
    bit sof;
    bit eof;
    int rem;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  mod3_frame_tx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
    .out_sof(out_sof), .out_eof(out_eof), .rem_r(rem_r)
  );

  // Downstream div_by_3 receiver model fed from out_bit
  always @(posedge clk) begin
    if (rst) rx <= 0;
    else     rx <= (2 * rx + int'(out_bit)) % 3;
  end

  function automatic int chk_of(input int w);
    return (3 - (w % 3)) % 3;
  endfunction

  task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_frame(input int w);
    item_t it;
    for (int i = 0; i < DATA_W; i++) begin
      it.b   = bit'((w >> (DATA_W - 1 - i)) & 1);
      it.sof = (i == 0);
      it.eof = 1'b0;
      it.rem = (w >> (DATA_W - i)) % 3;
      q.push_back(it);
    end
    it.sof = 1'b0;
    it.rem = w % 3;
    it.b   = bit'(chk_of(w) >> 1);
    it.eof = 1'b0;
    q.push_back(it);
    it.b   = bit'(chk_of(w) & 1);
    it.eof = 1'b1;
    q.push_back(it);
  endtask

  task automatic test_reset();
    tick(1'b1, 8'hFF, 1'b1);
    tick(1'b1, 8'h5A, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_bit !== 1'b0) $display("FAIL reset_bit: got %b expected 0", out_bit); else n_pass++;
    n_checks++; if (out_sof !== 1'b0) $display("FAIL reset_sof: got %b expected 0", out_sof); else n_pass++;
    n_checks++; if (out_eof !== 1'b0) $display("FAIL reset_eof: got %b expected 0", out_eof); else n_pass++;
    n_checks++; if (rem_r !== 2'd0) $display("FAIL reset_rem: got %0d expected 0", rem_r); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else n_pass++;
    tick(1'b0, 8'h00, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_frame(input logic [DATA_W-1:0] w);
    int fv, vcnt, nsof, sof_pos, neof, eof_pos, rdy_mask, rem_eof, exp_val;
    fv = 0; vcnt = 0; nsof = 0; sof_pos = -1; neof = 0; eof_pos = -1; rdy_mask = 0; rem_eof = -1;
    exp_val = int'(w) * 4 + chk_of(int'(w));
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ready_before_%h: got %b expected 1", w, in_ready); else n_pass++;
    tick(1'b1, w, 1'b0);
    for (int i = 0; i < FL; i++) begin
      if (out_valid === 1'b1) begin vcnt++; fv = fv * 2 + int'(out_bit); end
      if (out_sof === 1'b1) begin nsof++; sof_pos = i; end
      if (out_eof === 1'b1) begin neof++; eof_pos = i; rem_eof = int'(rem_r); end
      if (in_ready === 1'b1) rdy_mask |= (1 << i);
      tick(1'b0, DATA_W'($urandom), 1'b0);
    end
    n_checks++; if (fv != exp_val) $display("FAIL frame_value_%h: got %0d expected %0d", w, fv, exp_val); else n_pass++;
    n_checks++; if ((fv & 3) != chk_of(int'(w))) $display("FAIL check_bits_%h: got %0d expected %0d", w, fv & 3, chk_of(int'(w))); else n_pass++;
    n_checks++; if (vcnt != FL) $display("FAIL valid_count_%h: got %0d expected %0d", w, vcnt, FL); else n_pass++;
    n_checks++; if (nsof != 1 || sof_pos != 0) $display("FAIL sof_pos_%h: got count %0d pos %0d expected count 1 pos 0", w, nsof, sof_pos); else n_pass++;
    n_checks++; if (neof != 1 || eof_pos != FL - 1) $display("FAIL eof_pos_%h: got count %0d pos %0d expected count 1 pos %0d", w, neof, eof_pos, FL - 1); else n_pass++;
    n_checks++; if (rem_eof != int'(w) % 3) $display("FAIL rem_at_eof_%h: got %0d expected %0d", w, rem_eof, int'(w) % 3); else n_pass++;
    n_checks++; if (rdy_mask != (1 << (FL - 1))) $display("FAIL ready_mask_%h: got %h expected %h", w, rdy_mask, 1 << (FL - 1)); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_bit !== 1'b0) $display("FAIL idle_after_%h: got valid %b bit %b expected 0 0", w, out_valid, out_bit); else n_pass++;
  endtask

  task automatic test_frames();
    logic [DATA_W-1:0] words [6] = '{8'h05, 8'h00, 8'hFF, 8'h01, 8'h07, 8'h02};
    for (int k = 0; k < 6; k++) test_frame(words[k]);
  endtask

  task automatic test_back_to_back();
    int fv [2];
    int vcnt, sof_mask, eof_mask, rdy_mask, exp_eof;
    fv[0] = 0; fv[1] = 0; vcnt = 0; sof_mask = 0; eof_mask = 0; rdy_mask = 0;
    exp_eof = (1 << (FL - 1)) | (1 << (2 * FL - 1));
    tick(1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 2 * FL; i++) begin
      if (out_valid === 1'b1) begin vcnt++; fv[i / FL] = fv[i / FL] * 2 + int'(out_bit); end
      if (out_sof === 1'b1) sof_mask |= (1 << i);
      if (out_eof === 1'b1) eof_mask |= (1 << i);
      if (in_ready === 1'b1) rdy_mask |= (1 << i);
      tick(i != 2 * FL - 1, (i == FL - 1) ? 8'h02 : 8'h07, 1'b0);
    end
    n_checks++; if (vcnt != 2 * FL) $display("FAIL b2b_valid_count: got %0d expected %0d", vcnt, 2 * FL); else n_pass++;
    n_checks++; if (fv[0] != 7 * 4 + chk_of(7)) $display("FAIL b2b_frame0: got %0d expected %0d", fv[0], 7 * 4 + chk_of(7)); else n_pass++;
    n_checks++; if (fv[1] != 2 * 4 + chk_of(2)) $display("FAIL b2b_frame1: got %0d expected %0d", fv[1], 2 * 4 + chk_of(2)); else n_pass++;
    n_checks++; if (sof_mask != (1 | (1 << FL))) $display("FAIL b2b_sof_mask: got %h expected %h", sof_mask, 1 | (1 << FL)); else n_pass++;
    n_checks++; if (eof_mask != exp_eof) $display("FAIL b2b_eof_mask: got %h expected %h", eof_mask, exp_eof); else n_pass++;
    n_checks++; if (rdy_mask != exp_eof) $display("FAIL b2b_ready_mask: got %h expected %h", rdy_mask, exp_eof); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_idle: got valid %b ready %b expected 0 1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, DATA_W'($urandom), 1'b0);
    tick(1'b1, 8'h3C, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_bit !== 1'b0) $display("FAIL abort_bit: got %b expected 0", out_bit); else n_pass++;
    n_checks++; if (out_sof !== 1'b0 || out_eof !== 1'b0) $display("FAIL abort_flags: got sof %b eof %b expected 0 0", out_sof, out_eof); else n_pass++;
    n_checks++; if (rem_r !== 2'd0) $display("FAIL abort_rem: got %0d expected 0", rem_r); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", in_ready); else n_pass++;
    tick(1'b0, 8'h00, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_not_accepted: got %b expected 0", out_valid); else n_pass++;
    test_frame(8'h03);
  endtask

  task automatic test_random();
    int    sent = 0;
    int    cyc  = 0;
    bit    have_cur = 1'b0;
    bit    exp_ready, v;
    item_t cur;
    logic [DATA_W-1:0] d;
    while ((sent < 200 || q.size() > 0 || have_cur) && cyc < 6000) begin
      exp_ready = !have_cur || cur.eof;
      n_checks++; if (out_valid !== have_cur) $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, out_valid, have_cur); else n_pass++;
      n_checks++; if (out_bit !== (have_cur && cur.b)) $display("FAIL rnd_bit cyc %0d: got %b expected %b", cyc, out_bit, have_cur && cur.b); else n_pass++;
      n_checks++; if (out_sof !== (have_cur && cur.sof)) $display("FAIL rnd_sof cyc %0d: got %b expected %b", cyc, out_sof, have_cur && cur.sof); else n_pass++;
      n_checks++; if (out_eof !== (have_cur && cur.eof)) $display("FAIL rnd_eof cyc %0d: got %b expected %b", cyc, out_eof, have_cur && cur.eof); else n_pass++;
      n_checks++; if (in_ready !== exp_ready) $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready); else n_pass++;
      if (have_cur) begin
        n_checks++; if (int'(rem_r) != cur.rem) $display("FAIL rnd_rem cyc %0d: got %0d expected %0d", cyc, rem_r, cur.rem); else n_pass++;
      end
      if (!have_cur || cur.sof) begin
        n_checks++; if (rx != 0) $display("FAIL rnd_receiver cyc %0d: got %0d expected 0", cyc, rx); else n_pass++;
      end
      v = (sent < 200) && ($urandom_range(0, 2) != 0);
      d = DATA_W'($urandom);
      if (v && exp_ready) begin
        push_frame(int'(d));
        sent++;
      end
      tick(v, d, 1'b0);
      cyc++;
      if (q.size() > 0) begin
        cur = q.pop_front();
        have_cur = 1'b1;
      end else begin
        have_cur = 1'b0;
      end
    end
    n_checks++; if (cyc >= 6000) $display("FAIL rnd_timeout: got %0d cycles expected under 6000", cyc); else n_pass++;
    n_checks++; if (sent != 200) $display("FAIL rnd_sent: got %0d expected 200", sent); else n_pass++;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
